spi_rx_framer: RTL and testbench
================================

Name: spi_rx_framer

Overview:
- Downstream consumer of the SPI slave shift register. Watches the same spi_clk, counts bits and detects byte completion.
- Captures the shift register's parallel output (regout) into a small FIFO.
- Presents received bytes to the MIDI routing logic over a valid/ready interface.
- An idle timeout resynchronises bit framing across the inter-byte blank.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, 2..64.
- IDLE_CYCLES, 400, clk cycles with no spi_clk edge before the partial-byte bit counter is cleared. Fits a 16-bit counter.

Ports:
- clk  input  1  system clock, rising-edge.
- nreset  input  1  asynchronous active-low reset.
- spi_clk  input  1  raw SPI clock pin, asynchronous to clk, idle low (mode 0).
- regin  input  8  parallel byte from the shift register's regout.
- rx_data  output  8  FIFO head byte; valid while rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow.
- frame_err  output  1  one-cycle pulse: idle timeout discarded a partial byte.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (nreset).
  - Reset clears all state: rx_data=0, rx_valid=0, level=0, overflow=0, frame_err=0, bit count=0, pending=0, idle timer=0, FIFO pointers=0.
- Synchroniser:
  - spi_clk passes through a 2-FF synchroniser (s1, s2), then a third register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3. Both reset to 0.
- Bit counter, 3 bits, values 0..7:
  - On rise: if cnt==7, set pending=1 and cnt=0; otherwise cnt=cnt+1.
  - On fall with pending=1: push regin into the FIFO and clear pending. Regin is stable by then because the shift register updates on the rising edge.
- Latency:
  - The clk edge that first samples spi_clk low is edge 0.
  - The push occurs at edge 2.
  - rx_valid=1 and level increments after edge 2.
- Idle timer:
  - Cleared on any rise or fall; otherwise increments, saturating at IDLE_CYCLES.
  - When it reaches IDLE_CYCLES and cnt!=0: set cnt=0, set pending=0, pulse frame_err for 1 cycle, no push.
  - When it reaches IDLE_CYCLES and cnt==0: no action, no frame_err.
  - frame_err fires once per idle period.
- FIFO:
  - Show-ahead: rx_data = mem[rd_ptr] combinationally from registered storage; rx_data=0 when empty is not required beyond reset.
  - Pop when rx_valid & rx_ready.
  - No bypass: a push into an empty FIFO is visible the following cycle.
  - Push and pop in the same cycle, FIFO not empty: both take effect, level unchanged.
  - Push and pop in the same cycle, FIFO full: both take effect, level stays DEPTH.
  - Push when full without a pop: byte dropped, overflow set to 1.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. level is the pointer difference plus a full flag, or an explicit counter.
- overflow: if ovf_clr and a new drop occur in the same cycle, set wins. ovf_clr has no other effect.
- rx_ready while empty: ignored; no pointer change.
- nreset asserted mid-byte: framing restarts cleanly at the first rise after release. Any partial bits are lost.

Decomposition:
- Package spi_pkg:
  - typedef logic [7:0] spi_byte_t
  - localparam defaults SPI_FIFO_DEPTH=8 and SPI_IDLE_CYCLES=400 (400 cycles = 4 µs at 100 MHz clk with 1 MHz SCK).
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH:
  - ports clk, nreset, push, din, pop, dout, empty, full, level.
  - Reusable by the future TX path.
- The framer top holds the synchroniser, edge detector, bit counter, idle timer and overflow logic.

Test Plan:
1. Single byte: regin=8'hA5, 8 SCK pulses at 1 MHz -> rx_valid high exactly 3 clk edges after the 8th falling edge, rx_data=8'hA5, level=1. rx_ready pulse -> rx_valid=0, level=0.
2. Burst of DEPTH+1 bytes, bytes 0x01..0x09, rx_ready=0 -> level=8, overflow=1. Drain yields 0x01..0x08 in order, 0x09 absent. ovf_clr -> overflow=0.
3. Full FIFO, then a push coinciding with a pop cycle -> no overflow, level stays 8, ordering preserved.
4. 5 SCK pulses, then idle for 500 clk -> one frame_err pulse, no push. Next 8 pulses with regin=8'h3C -> rx_data=8'h3C.
5. nreset asserted after 4 SCK pulses with a byte queued -> all outputs 0 immediately. After release, a full byte 8'h5A is received correctly.
6. rx_ready held high continuously with bytes every 10 µs -> each byte is valid for exactly 1 cycle, level never exceeds 1, no overflow.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared byte type and default sizing for the SPI receive path
`timescale 1ns/1ps
package spi_pkg;
  typedef logic [7:0] spi_byte_t;
  localparam int SPI_FIFO_DEPTH = 8;
  localparam int SPI_IDLE_CYCLES = 400;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO with explicit occupancy counter
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] level_q, level_d;
  logic wr, rd;
  always_comb begin
    empty = level_q == '0;
    full = level_q == FULL_LEVEL;
    wr = push & (~full | pop);
    rd = pop & ~empty;
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d = level_q + (PW+1)'(wr) - (PW+1)'(rd);
    dout = mem_q[rd_ptr_q];
    level = level_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/spi_rx_framer.sv
// spi_rx_framer: frames SPI slave bytes by spi_clk edge counting into a valid/ready FIFO
`timescale 1ns/1ps
module spi_rx_framer
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int IDLE_CYCLES = SPI_IDLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   spi_clk,
  input  logic [7:0]             regin,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   frame_err
);
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYCLES);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
  logic s1_q, s2_q, s3_q;
  logic [2:0] cnt_q, cnt_d;
  logic pending_q, pending_d;
  logic [15:0] idle_q, idle_d;
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic rise, fall, timeout, push, pop, empty, full;
  spi_byte_t fifo_dout;
  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    timeout = ~rise & ~fall & (idle_q == IDLE_LAST);
    push = fall & pending_q;
    pop = ~empty & rx_ready;
    idle_d = (rise | fall) ? '0 : (idle_q == IDLE_MAX) ? idle_q : idle_q + 16'd1;
    cnt_d = rise ? cnt_q + 3'd1 : timeout ? 3'd0 : cnt_q;
    pending_d = (rise & (cnt_q == 3'd7)) ? 1'b1 : (push | (timeout & (cnt_q != 3'd0))) ? 1'b0 : pending_q;
    frame_err_d = timeout & (cnt_q != 3'd0);
    overflow_d = (push & full & ~pop) | (overflow_q & ~ovf_clr);
    rx_data = fifo_dout;
    rx_valid = ~empty;
    overflow = overflow_q;
    frame_err = frame_err_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      cnt_q <= '0;
      pending_q <= 1'b0;
      idle_q <= '0;
      overflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_q <= spi_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      idle_q <= idle_d;
      overflow_q <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nreset(nreset),
    .push(push),
    .din(regin),
    .pop(pop),
    .dout(fifo_dout),
    .empty(empty),
    .full(full),
    .level(level)
  );
endmodule

// File: tb/tb_spi_rx_framer.sv
// tb_spi_rx_framer: randomized and directed checks of spi_rx_framer against a byte-queue model
`timescale 1ns/1ps
module tb_spi_rx_framer;
  localparam int DEPTH = 8;
  logic clk = 0, nreset = 0, spi_clk = 0, rx_ready = 0, ovf_clr = 0;
  logic [7:0] regin = 0, rx_data;
  logic rx_valid, overflow, frame_err;
  logic [3:0] level;
  int n_chk = 0, n_pass = 0, ferr_cnt = 0, max_level = 0, vcnt = 0, hp = 500;
  byte unsigned exp_q[$];
  logic ovf_exp = 0;
  always #5 clk = ~clk;
  spi_rx_framer #(.DEPTH(DEPTH), .IDLE_CYCLES(400)) dut (
    .clk(clk),
    .nreset(nreset),
    .spi_clk(spi_clk),
    .regin(regin),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .level(level),
    .overflow(overflow),
    .ovf_clr(ovf_clr),
    .frame_err(frame_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) if (nreset) begin
    if (frame_err) ferr_cnt++;
    if (rx_valid) vcnt++;
    if (int'(level) > max_level) max_level = int'(level);
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("spurious_valid", rx_valid, 0);
      else chk("rx_data", rx_data, exp_q.pop_front());
    end
  end
  task automatic send_byte(input logic [7:0] b, input bit coincide = 0);
    for (int i = 0; i < 8; i++) begin
      #(hp) spi_clk = 1; regin = (i == 7) ? b : 8'($urandom);
      #(hp) spi_clk = 0;
    end
    if (exp_q.size() < DEPTH || coincide) exp_q.push_back(b);
    else ovf_exp = 1;
    if (coincide) begin
      repeat (2) @(posedge clk);
      #1 rx_ready = 1;
      @(posedge clk);
      #1 rx_ready = 0;
    end
  endtask
  task automatic partial(input int k);
    for (int i = 0; i < k; i++) begin
      #(hp) spi_clk = 1; regin = 8'($urandom);
      #(hp) spi_clk = 0;
    end
  endtask
  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic drain(input int n);
    rx_ready = 1;
    repeat (n) @(posedge clk);
    #1 rx_ready = 0;
    settle();
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_level"}, level, exp_q.size());
    chk({tag, "_overflow"}, overflow, ovf_exp);
  endtask
  initial begin
    int f0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    #2 nreset = 1;
    // single byte with exact latency
    send_byte(8'hA5);
    repeat (2) @(posedge clk);
    #1 chk("lat_early", rx_valid, 0);
    @(posedge clk);
    #1 chk("lat_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_level", level, 1);
    drain(1);
    chk("t1_empty", rx_valid, 0);
    chk_state("t1");
    // burst of DEPTH+1 with overflow
    hp = 100;
    for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i));
    settle();
    chk("t2_level", level, DEPTH);
    chk("t2_ovf", overflow, 1);
    chk_state("t2");
    drain(DEPTH + 2);
    chk("t2_empty", rx_valid, 0);
    chk_state("t2_drained");
    #1 ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    ovf_exp = 0;
    chk("t2_ovf_clr", overflow, 0);
    // full FIFO, push coinciding with pop
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
    settle();
    chk_state("t3_full");
    send_byte(8'hC7, 1);
    settle();
    chk("t3_ovf", overflow, 0);
    chk("t3_level", level, DEPTH);
    drain(DEPTH + 2);
    chk_state("t3_drained");
    // idle timeout discards partial byte
    chk("no_ferr_full_bytes", ferr_cnt, 0);
    f0 = ferr_cnt;
    partial(5);
    repeat (500) @(posedge clk);
    #1 chk("t4_ferr_once", ferr_cnt - f0, 1);
    chk("t4_no_push", level, 0);
    send_byte(8'h3C);
    settle();
    chk("t4_data", rx_data, 8'h3C);
    drain(2);
    chk_state("t4");
    // reset mid-byte with a byte queued
    send_byte(8'h77);
    partial(4);
    #20 nreset = 0;
    exp_q.delete();
    ovf_exp = 0;
    #1;
    chk("t5_valid", rx_valid, 0);
    chk("t5_level", level, 0);
    chk("t5_data", rx_data, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_ferr", frame_err, 0);
    #50 nreset = 1;
    send_byte(8'h5A);
    settle();
    chk("t5_data_after", rx_data, 8'h5A);
    chk("t5_level_after", level, 1);
    drain(2);
    // continuous ready, spaced bytes
    hp = 500;
    rx_ready = 1;
    max_level = 0;
    for (int i = 0; i < 3; i++) begin
      vcnt = 0;
      send_byte(8'($urandom));
      #2000;
      chk("t6_valid_cycles", vcnt, 1);
    end
    rx_ready = 0;
    chk("t6_max_level", max_level <= 1, 1);
    chk_state("t6");
    // randomized mix of bursts, drains, partial bytes and clears
    for (int it = 0; it < 30; it++) begin
      hp = 10 * $urandom_range(4, 10);
      if ($urandom_range(0, 9) == 0) begin
        f0 = ferr_cnt;
        partial($urandom_range(1, 7));
        repeat (450) @(posedge clk);
        #1 chk("rnd_ferr", ferr_cnt - f0, 1);
      end else begin
        for (int b = 0, n = $urandom_range(1, 4); b < n; b++) send_byte(8'($urandom));
        settle();
      end
      chk_state("rnd_fill");
      drain($urandom_range(0, 6));
      chk_state("rnd_drain");
      if (ovf_exp && $urandom_range(0, 1) == 1) begin
        ovf_clr = 1;
        @(posedge clk);
        #1 ovf_clr = 0;
        ovf_exp = 0;
        chk("rnd_ovf_clr", overflow, 0);
      end
    end
    drain(DEPTH + 2);
    chk_state("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
